// File: rtl/pwm_reg_core_pkg.sv
// Shared definitions for the PWM register core: register addresses,
// CTRL bit positions and the edge detector mode selector.
package pwm_reg_core_pkg;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PRESCALE = 2'd1;
    localparam logic [1:0] ADDR_PERIOD   = 2'd2;
    localparam logic [1:0] ADDR_DUTY     = 2'd3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_INV = 1;
    localparam int CTRL_CLR = 2;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

endpackage

// File: rtl/pwm_reg_core_edge_detector.sv
// Edge detector: single-clock pulse on the selected edge of sig_i.
// Ports:
//   clk, rst_n  clock and async active-low reset
//   sig_i       level input (already in the clk domain)
//   pulse_o     combinational pulse, high for the clk in which the edge is seen
module edge_detector
    import pwm_reg_core_pkg::*;
#(
    parameter edge_mode_e MODE = EDGE_RISE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic pulse_o
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    always_comb begin
        pulse_o = 1'b0;
        case (MODE)
            EDGE_RISE: pulse_o = sig_i & ~sig_q;
            EDGE_FALL: pulse_o = ~sig_i & sig_q;
            EDGE_BOTH: pulse_o = sig_i ^ sig_q;
            default:   pulse_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pwm_reg_core.sv
// PWM register core: four-register bank written from the SPI slave port and a
// prescaled PWM generator. PERIOD/DUTY are staged and copied into the active
// set only on a period wrap (or while disabled / on clr), so pwm_o never glitches.
// Ports:
//   clk, rst_n  system clock, async active-low reset
//   addr_i      register address
//   data_wr_i   write data
//   wr_en_i     write enable level; one write per rising edge
//   data_rd_o   combinational read data for addr_i
//   pwm_o       registered PWM output
//   cycle_o     registered one-clk pulse on each period wrap
module pwm_reg_core
    import pwm_reg_core_pkg::*;
#(
    parameter logic [7:0] PERIOD_RST = 8'hFF,
    parameter logic [7:0] DUTY_RST   = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] addr_i,
    input  logic [7:0] data_wr_i,
    input  logic       wr_en_i,
    output logic [7:0] data_rd_o,
    output logic       pwm_o,
    output logic       cycle_o
);

    logic       wr_pulse;
    logic       ctrl_en;
    logic       ctrl_inv;
    logic [7:0] prescale;
    logic [7:0] period_stg;
    logic [7:0] duty_stg;
    logic [7:0] period_act;
    logic [7:0] duty_act;
    logic [7:0] pre_cnt;
    logic [7:0] cnt;
    logic       tick;
    logic       wrap;
    logic       clr_hit;

    edge_detector #(.MODE(EDGE_RISE)) u_wr_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig_i   (wr_en_i),
        .pulse_o (wr_pulse)
    );

    always_comb begin
        tick    = ctrl_en && (pre_cnt == prescale);
        wrap    = tick && (cnt == period_act);
        clr_hit = wr_pulse && (addr_i == ADDR_CTRL) && data_wr_i[CTRL_CLR];
    end

    // Register file: staging registers and CTRL bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en    <= 1'b0;
            ctrl_inv   <= 1'b0;
            prescale   <= 8'h00;
            period_stg <= PERIOD_RST;
            duty_stg   <= DUTY_RST;
        end else if (wr_pulse) begin
            case (addr_i)
                ADDR_CTRL: begin
                    ctrl_en  <= data_wr_i[CTRL_EN];
                    ctrl_inv <= data_wr_i[CTRL_INV];
                end
                ADDR_PRESCALE: prescale   <= data_wr_i;
                ADDR_PERIOD:   period_stg <= data_wr_i;
                ADDR_DUTY:     duty_stg   <= data_wr_i;
                default: ;
            endcase
        end
    end

    // Prescaler, period counter and active-set reload. Staging is read before
    // this edge's write lands, so a write coinciding with a wrap applies one
    // period later. A shrunk PRESCALE lets pre_cnt run up through 8'hFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt    <= 8'h00;
            cnt        <= 8'h00;
            period_act <= PERIOD_RST;
            duty_act   <= DUTY_RST;
        end else if (clr_hit || !ctrl_en) begin
            pre_cnt    <= 8'h00;
            cnt        <= 8'h00;
            period_act <= period_stg;
            duty_act   <= duty_stg;
        end else if (tick) begin
            pre_cnt <= 8'h00;
            if (wrap) begin
                cnt        <= 8'h00;
                period_act <= period_stg;
                duty_act   <= duty_stg;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end else begin
            pre_cnt <= pre_cnt + 8'd1;
        end
    end

    // Output stage: one clk behind the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_o   <= 1'b0;
            cycle_o <= 1'b0;
        end else begin
            pwm_o   <= ctrl_en ? ((cnt < duty_act) ^ ctrl_inv) : ctrl_inv;
            cycle_o <= wrap;
        end
    end

    always_comb begin
        data_rd_o = 8'h00;
        case (addr_i)
            ADDR_CTRL:     data_rd_o = {pwm_o, 4'b0000, 1'b0, ctrl_inv, ctrl_en};
            ADDR_PRESCALE: data_rd_o = prescale;
            ADDR_PERIOD:   data_rd_o = period_stg;
            ADDR_DUTY:     data_rd_o = duty_stg;
            default:       data_rd_o = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_pwm_reg_core.sv
module tb_pwm_reg_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] addr_i = 2'd0;
    logic [7:0] data_wr_i = 8'h00;
    logic       wr_en_i = 1'b0;
    logic [7:0] data_rd_o;
    logic       pwm_o;
    logic       cycle_o;

    int checks = 0;
    int errors = 0;

    // Reference model state (plain integers, spec-level rules).
    int m_en, m_inv, m_presc, m_pstg, m_dstg, m_pact, m_dact;
    int m_pre, m_cnt, m_pwm, m_cyc, m_wprev;

    logic [1:0] exp_q[$];

    pwm_reg_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_i    (addr_i),
        .data_wr_i (data_wr_i),
        .wr_en_i   (wr_en_i),
        .data_rd_o (data_rd_o),
        .pwm_o     (pwm_o),
        .cycle_o   (cycle_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_inv = 0; m_presc = 0;
        m_pstg = 255; m_dstg = 0; m_pact = 255; m_dact = 0;
        m_pre = 0; m_cnt = 0; m_pwm = 0; m_cyc = 0; m_wprev = 0;
    endtask

    // One clock of the specified behaviour, given the inputs present at the edge.
    task automatic model_step(input int a, input int d, input int we);
        int pulse, clr, tick, wrap;
        pulse   = (we == 1 && m_wprev == 0) ? 1 : 0;
        m_wprev = we;
        clr     = (pulse == 1 && a == 0 && ((d >> 2) & 1) == 1) ? 1 : 0;
        tick    = (m_en == 1 && m_pre == m_presc) ? 1 : 0;
        wrap    = (tick == 1 && m_cnt == m_pact) ? 1 : 0;
        if (m_en == 1) m_pwm = ((m_cnt < m_dact) ? 1 : 0) ^ m_inv;
        else           m_pwm = m_inv;
        m_cyc = wrap;
        if (clr == 1 || m_en == 0) begin
            m_pre = 0; m_cnt = 0; m_pact = m_pstg; m_dact = m_dstg;
        end else if (tick == 1) begin
            m_pre = 0;
            if (wrap == 1) begin
                m_cnt = 0; m_pact = m_pstg; m_dact = m_dstg;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            m_pre = (m_pre + 1) % 256;
        end
        if (pulse == 1) begin
            case (a)
                0: begin m_en = d & 1; m_inv = (d >> 1) & 1; end
                1: m_presc = d;
                2: m_pstg = d;
                default: m_dstg = d;
            endcase
        end
    endtask

    function automatic int model_rd(input int a);
        case (a)
            0: return (m_pwm << 7) | (m_inv << 1) | m_en;
            1: return m_presc;
            2: return m_pstg;
            default: return m_dstg;
        endcase
    endfunction

    // Stimulus side of the scoreboard: predict each clk's outputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step(int'(addr_i), int'(data_wr_i), int'(wr_en_i));
            exp_q.push_back({m_pwm[0], m_cyc[0]});
        end
    end

    // Monitor: compare away from the active edge.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst_n) begin
            check("rst_pwm", int'(pwm_o), 0);
            check("rst_cycle", int'(cycle_o), 0);
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            check("pwm_o", int'(pwm_o), int'(e[1]));
            check("cycle_o", int'(cycle_o), int'(e[0]));
            check("data_rd", int'(data_rd_o), model_rd(int'(addr_i)));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            addr_i = 2'($urandom);
        end
    endtask

    // Write with wr_en_i held for 'hold' clks; data is scrambled after the first edge.
    task automatic wr(input logic [1:0] a, input logic [7:0] d, input int hold);
        @(posedge clk);
        #1;
        addr_i = a; data_wr_i = d; wr_en_i = 1'b1;
        repeat (hold) begin
            @(posedge clk);
            #1;
            data_wr_i = 8'($urandom);
        end
        wr_en_i = 1'b0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        wr_en_i = 1'b0;
        addr_i  = 2'd2;
        rst_n   = 1'b0;
        #1;
        check("rst_now_pwm", int'(pwm_o), 0);
        check("rst_now_cycle", int'(cycle_o), 0);
        check("rst_now_period", int'(data_rd_o), 255);
        addr_i = 2'd0;
        #1;
        check("rst_now_ctrl", int'(data_rd_o), 0);
        addr_i = 2'd3;
        #1;
        check("rst_now_duty", int'(data_rd_o), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        addr_i = 2'd2;
        #1;
        check("t1_period_rd", int'(data_rd_o), 255);
        addr_i = 2'd0;
        #1;
        check("t1_ctrl_rd", int'(data_rd_o), 0);
        check("t1_pwm", int'(pwm_o), 0);
        check("t1_cycle", int'(cycle_o), 0);

        // Basic 2-high / 2-low waveform.
        wr(2'd1, 8'd0, 1);
        wr(2'd2, 8'd3, 1);
        wr(2'd3, 8'd2, 1);
        wr(2'd0, 8'd1, 1);
        idle(16);

        // Held write enable: only the first value lands.
        @(posedge clk);
        #1;
        addr_i = 2'd3; data_wr_i = 8'd5; wr_en_i = 1'b1;
        @(posedge clk);
        #1;
        data_wr_i = 8'd7;
        repeat (9) @(posedge clk);
        #1;
        check("t3_duty_held", int'(data_rd_o), 5);
        wr_en_i = 1'b0;
        idle(12);

        // Duty change mid-period, then boundary duties and inversion.
        wr(2'd3, 8'd2, 1);
        idle(9);
        wr(2'd3, 8'd1, 1);
        idle(16);
        wr(2'd3, 8'd0, 1);
        idle(12);
        wr(2'd3, 8'd9, 1);
        idle(12);
        wr(2'd0, 8'd3, 1);
        idle(12);
        wr(2'd3, 8'd0, 1);
        idle(12);

        // PERIOD=0 and slower prescale, then async reset mid-period.
        wr(2'd0, 8'd1, 1);
        wr(2'd2, 8'd0, 1);
        idle(10);
        wr(2'd2, 8'd3, 1);
        wr(2'd3, 8'd2, 1);
        wr(2'd1, 8'd2, 1);
        idle(20);
        async_reset();

        // Shrinking PRESCALE below pre_cnt, then clr with en/inv.
        wr(2'd2, 8'd2, 1);
        wr(2'd3, 8'd1, 1);
        wr(2'd1, 8'd200, 1);
        wr(2'd0, 8'd1, 1);
        idle(30);
        wr(2'd1, 8'd3, 2);
        idle(260);
        wr(2'd0, 8'd7, 1);
        idle(10);

        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [1:0] a;
            logic [7:0] d;
            r = $urandom_range(0, 99);
            a = 2'($urandom);
            case (a)
                2'd0: d = {5'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom_range(0, 4) != 0)};
                2'd1: d = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
                2'd2: d = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
                default: d = 8'($urandom_range(0, 9));
            endcase
            if (r < 55)      idle($urandom_range(1, 6));
            else if (r < 99) wr(a, d, $urandom_range(1, 4));
            else             async_reset();
        end

        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
